// File: rtl/seq_div32.sv
// Sequential 32/32 restoring divider, signed or unsigned, with a start/busy/done handshake.
// One quotient bit per cycle; fixed 34-cycle throughput regardless of data or divide-by-zero.
module seq_div32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [32:0] r_a;
  logic [31:0] r_q;
  logic [31:0] r_m;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_busy;
  logic        r_done;
  logic        r_div_by_zero;

  logic [32:0] w_a_sh;
  logic [32:0] w_t;
  logic [31:0] w_dvd_abs;
  logic [31:0] w_dvs_abs;
  logic [31:0] w_q_neg;
  logic [31:0] w_r_neg;

  always_comb begin
    w_a_sh    = {r_a[31:0], r_q[31]};
    w_t       = w_a_sh - {1'b0, r_m};
    w_dvd_abs = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    w_dvs_abs = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
    w_q_neg   = ~r_q + 32'd1;
    w_r_neg   = ~r_a[31:0] + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_a           <= 33'd0;
      r_q           <= 32'd0;
      r_m           <= 32'd0;
      r_cnt         <= 6'd0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= 32'd0;
      r_remainder   <= 32'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_neg_q <= is_signed & (dividend[31] ^ divisor[31]);
            r_neg_r <= is_signed & dividend[31];
            r_dz    <= (divisor == 32'd0);
            r_q     <= w_dvd_abs;
            r_m     <= w_dvs_abs;
            r_a     <= 33'd0;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 6'd1;
          if (!w_t[32]) begin
            r_a <= w_t;
            r_q <= {r_q[30:0], 1'b1};
          end else begin
            r_a <= w_a_sh;
            r_q <= {r_q[30:0], 1'b0};
          end
          if (r_cnt == 6'd31) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // With M=0 every step subtracts nothing, so A ends as |dividend| and the
          // sign-corrected remainder already equals the original dividend.
          r_quotient    <= r_dz ? 32'hFFFF_FFFF : (r_neg_q ? w_q_neg : r_q);
          r_remainder   <= r_neg_r ? w_r_neg : r_a[31:0];
          r_div_by_zero <= r_dz;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: doc/seq_div32.md
# seq_div32

Sequential 32/32 restoring divider, the inverse companion of the shift-add multiplier in the ALU. It produces a 32-bit quotient and a 32-bit remainder in a fixed number of cycles. It supports unsigned and signed (two's complement) division through an `is_signed` input, and uses the same start/busy/done handshake as the multiplier so the ALU control FSM drives both units the same way.

## Interface
- No parameters; all widths are fixed at 32 bits.
- `clk` input 1: sole clock; everything is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `is_signed` input 1: 1 = signed division, 0 = unsigned; sampled with `start`.
- `dividend` input 32: numerator; sampled with `start`.
- `divisor` input 32: denominator; sampled with `start`.
- `quotient` output 32: registered result; holds until the next completion.
- `remainder` output 32: registered result; holds until the next completion.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when the results update.
- `div_by_zero` output 1: registered flag, valid while `done`=1; holds until the next completion.

## Operation
- States: IDLE, RUN, DONE. Encoding values outside these states go to IDLE.
- **IDLE, `start`=1:**
  - Latch `neg_q` = `is_signed` & (`dividend[31]` ^ `divisor[31]`).
  - Latch `neg_r` = `is_signed` & `dividend[31]`.
  - Latch `dz` = (`divisor`==0).
  - Load Q = |dividend| and M = |divisor| when `is_signed`=1, otherwise the raw values.
  - Clear the 33-bit partial remainder A and the 6-bit count.
  - Set `busy`=1 and go to RUN.
- **IDLE, `start`=0:** hold all registers.
- **RUN, one step per cycle, 32 steps:**
  - Shift {A,Q} left by 1.
  - Compute T = A − {1'b0,M} in 33 bits.
  - If T[32]=0: A=T and Q[0]=1.
  - Otherwise: keep the shifted A and set Q[0]=0.
  - When count==31, go to DONE. Count increments every RUN cycle.
- **DONE:**
  - `quotient` = `neg_q` ? −Q : Q.
  - `remainder` = `neg_r` ? −A[31:0] : A[31:0].
  - Both negations are 32-bit two's complement.
  - Set `div_by_zero`=`dz`, pulse `done`=1, set `busy`=0, return to IDLE.
- **Divide by zero:** takes the same fixed path. The results are forced to `quotient`=0xFFFFFFFF and `remainder`=original `dividend` (sign correction is bypassed).
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives `quotient`=0x80000000, `remainder`=0, `div_by_zero`=0. No special casing is needed: the magnitude of 0x80000000 is 0x80000000 unsigned.
- **Remainder sign:** follows the dividend (truncating division). `quotient`×`divisor`+`remainder` equals `dividend` mod 2^32 for every non-zero divisor.
- **`start` while busy:** `start` in RUN or DONE is ignored. No queueing, no restart.
- **Operand changes:** inputs changing after the `start` edge have no effect on the operation in progress.

## Timing
- **Reset (`reset`=0, asynchronous):**
  - State goes to IDLE.
  - `quotient`, `remainder` = 0.
  - `busy`, `done`, `div_by_zero` = 0.
  - A, Q, M, count, `neg_q`, `neg_r`, `dz` = 0.
  - Reset takes effect immediately, even mid-operation; the aborted operation never raises `done`.
- **Latency:** `start` sampled high at edge E0.
  - `busy`=1 after E0.
  - RUN steps execute on E1..E32.
  - DONE executes on E33: `done`=1 and results are valid after E33.
  - `busy` falls on the same edge E33 that raises `done`.
  - `done` falls after E34.
- **Back-to-back:** a new `start` is accepted at E34 at the earliest, since the unit is in IDLE during the cycle `done` is high. A `start` presented at E33 is ignored.
- **Throughput:** one operation per 34 cycles. Latency is fixed and does not depend on the data or on `div_by_zero`.

## Test plan
- Unsigned 100 / 7 -> `quotient`=14, `remainder`=2, `div_by_zero`=0; `done` exactly 33 edges after the start edge, width 1 cycle.
- Signed 0xFFFFFFF9 (−7) / 2 -> `quotient`=0xFFFFFFFD (−3), `remainder`=0xFFFFFFFF (−1). Same operands unsigned -> `quotient`=0x7FFFFFFC, `remainder`=1.
- Signed 0x80000000 / 0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0. Unsigned 0xFFFFFFFF / 1 -> `quotient`=0xFFFFFFFF, `remainder`=0.
- 1234 / 0 (signed and unsigned) -> `quotient`=0xFFFFFFFF, `remainder`=1234, `div_by_zero`=1, same 33-cycle latency. A following 9 / 3 -> `div_by_zero`=0, `quotient`=3, `remainder`=0.
- Assert `start` with 50/5 at E0, then `start` with 1/1 at E10 and at E33 -> exactly one `done`, `quotient`=10, `remainder`=0. A `start` at E34 is accepted.
- Drive `reset` low at E15 of a running operation -> all outputs 0 immediately, state IDLE, no `done`. After release, 20 / 6 -> `quotient`=3, `remainder`=2.
